// File: rtl/rcp_arbiter.sv
// Time-shares one combinational reciprocal between NREQ requesters: latch operand, settle, capture, pulse done.
// Latency: done pulses SETTLE+1 edges after the grant edge; one job in flight, back-to-back every SETTLE+2 cycles.
// Backpressure: requesters hold i_req until their done pulse; losers simply wait, nothing is dropped.
module rcp_arbiter #(
    parameter int NREQ   = 3,
    parameter int W      = 24,
    parameter int SETTLE = 1,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_flush,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*W-1:0] i_data,
    output logic [NREQ-1:0]   o_gnt,
    output logic [NREQ-1:0]   o_done,
    output logic [W-1:0]      o_result,
    output logic              o_sat,
    output logic              o_busy,
    output logic [W-1:0]      rcp_in,
    input  logic [W-1:0]      rcp_out,
    input  logic              rcp_sat
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [LW-1:0]   last;
    logic [NREQ-1:0] elig;
    logic [LW-1:0]   win;
    logic            win_vld;

    function automatic logic [NREQ-1:0] onehot(input logic [LW-1:0] k);
        logic [NREQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // The requester in its done cycle is masked so it has time to drop i_req.
    always_comb begin
        int idx;
        idx     = 0;
        elig    = i_req & ~o_done;
        win     = '0;
        win_vld = 1'b0;
        if (RR != 0) begin
            for (int i = 1; i <= NREQ; i++) begin
                idx = (int'(last) + i) % NREQ;
                if (!win_vld && elig[idx]) begin
                    win     = LW'(idx);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    win     = LW'(i);
                    win_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            o_gnt    <= '0;
            o_done   <= '0;
            o_result <= '0;
            o_sat    <= 1'b0;
            o_busy   <= 1'b0;
            rcp_in   <= '0;
            cnt      <= '0;
            last     <= LW'(NREQ - 1);
        end else if (i_flush) begin
            state  <= IDLE;
            o_gnt  <= '0;
            o_done <= '0;
            o_busy <= 1'b0;
            cnt    <= '0;
        end else begin
            o_done <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        o_gnt  <= onehot(win);
                        rcp_in <= i_data[int'(win)*W +: W];
                        cnt    <= 4'(SETTLE);
                        o_busy <= 1'b1;
                        last   <= win;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // last still holds the current owner, so it doubles as the done index.
                        o_result <= rcp_out;
                        o_sat    <= rcp_sat;
                        o_done   <= onehot(last);
                        o_gnt    <= '0;
                        o_busy   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rcp_arbiter.sv
// Two arbiters (round-robin SETTLE=1, fixed-priority SETTLE=2) on shared stimulus against a job-level model.
module tb_rcp_arbiter;
    localparam int NREQ = 3;
    localparam int W    = 24;

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         sat;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic              i_flush;
    logic [NREQ-1:0]   i_req;
    logic [NREQ*W-1:0] i_data;
    logic [NREQ-1:0]   o_gnt [2];
    logic [NREQ-1:0]   o_done [2];
    logic [W-1:0]      o_result [2];
    logic              o_sat [2];
    logic              o_busy [2];
    logic [W-1:0]      rcp_in [2];
    logic [W-1:0]      rcp_out [2];
    logic              rcp_sat [2];

    int n_vec = 0;
    int n_err = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic [NREQ-1:0] ord[$];

    int           m_busy [2]  = '{0, 0};
    int           m_owner [2] = '{0, 0};
    int           m_left [2]  = '{0, 0};
    int           m_last [2]  = '{NREQ - 1, NREQ - 1};
    int           m_done [2]  = '{-1, -1};
    logic [W-1:0] m_rcp [2]   = '{'0, '0};

    // Q12.12 reciprocal: 2^24 / x, saturating to all-ones when the result does not fit.
    function automatic logic [W:0] rcp_model(input logic [W-1:0] x);
        if (x < 24'd2) return {1'b1, {W{1'b1}}};
        return {1'b0, W'(32'h0100_0000 / 32'(x))};
    endfunction

    function automatic logic [NREQ-1:0] oh(input int k);
        logic [NREQ-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input bit rr, input logic [NREQ-1:0] req, input int done_idx, input int lst);
        for (int off = 0; off < NREQ; off++) begin
            int k;
            k = rr ? (lst + 1 + off) % NREQ : off;
            if (req[k] && k != done_idx) return k;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return W'(1);
            2:       return 24'h002000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check(input int j, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s inst%0d got=%h want=%h at %0t", nm, j, act, exp_v, $time);
        end
    endtask

    assign {rcp_sat[0], rcp_out[0]} = rcp_model(rcp_in[0]);
    assign {rcp_sat[1], rcp_out[1]} = rcp_model(rcp_in[1]);

    rcp_arbiter #(.NREQ(NREQ), .W(W), .SETTLE(1), .RR(1)) u_rr (
        .clk(clk), .reset_n(reset_n), .i_flush(i_flush), .i_req(i_req), .i_data(i_data),
        .o_gnt(o_gnt[0]), .o_done(o_done[0]), .o_result(o_result[0]), .o_sat(o_sat[0]),
        .o_busy(o_busy[0]), .rcp_in(rcp_in[0]), .rcp_out(rcp_out[0]), .rcp_sat(rcp_sat[0])
    );

    rcp_arbiter #(.NREQ(NREQ), .W(W), .SETTLE(2), .RR(0)) u_fp (
        .clk(clk), .reset_n(reset_n), .i_flush(i_flush), .i_req(i_req), .i_data(i_data),
        .o_gnt(o_gnt[1]), .o_done(o_done[1]), .o_result(o_result[1]), .o_sat(o_sat[1]),
        .o_busy(o_busy[1]), .rcp_in(rcp_in[1]), .rcp_out(rcp_out[1]), .rcp_sat(rcp_sat[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Job-level reference: who owns the reciprocal, how many edges remain, and what it will return.
    always @(posedge clk or negedge reset_n) begin
        int       w;
        int       st;
        logic [W:0] rs;
        exp_t     e;
        for (int j = 0; j < 2; j++) begin
            st = (j == 0) ? 1 : 2;
            if (!reset_n) begin
                m_busy[j]  = 0;
                m_owner[j] = 0;
                m_left[j]  = 0;
                m_last[j]  = NREQ - 1;
                m_done[j]  = -1;
                m_rcp[j]   = '0;
            end else if (i_flush) begin
                m_busy[j] = 0;
                m_done[j] = -1;
            end else if (m_busy[j] != 0) begin
                m_done[j] = -1;
                m_left[j]--;
                if (m_left[j] == 0) begin
                    rs    = rcp_model(m_rcp[j]);
                    e.idx = m_owner[j];
                    e.res = rs[W-1:0];
                    e.sat = rs[W];
                    if (j == 0) q0.push_back(e);
                    else        q1.push_back(e);
                    m_busy[j] = 0;
                    m_done[j] = m_owner[j];
                end
            end else begin
                w = pick(j == 0, i_req, m_done[j], m_last[j]);
                m_done[j] = -1;
                if (w >= 0) begin
                    m_busy[j]  = 1;
                    m_owner[j] = w;
                    m_left[j]  = st + 1;
                    m_last[j]  = w;
                    m_rcp[j]   = i_data[w*W +: W];
                end
            end
        end
        if (!reset_n) begin
            q0.delete();
            q1.delete();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (reset_n === 1'b1) begin
            for (int j = 0; j < 2; j++) begin
                check(j, "gnt", 32'(o_gnt[j]), 32'(oh(m_busy[j] != 0 ? m_owner[j] : -1)));
                check(j, "gnt_onehot", 32'($onehot0(o_gnt[j])), 32'd1);
                check(j, "busy", 32'(o_busy[j]), 32'(m_busy[j] != 0));
                check(j, "done", 32'(o_done[j]), 32'(oh(m_done[j])));
                check(j, "rcp_in", 32'(rcp_in[j]), 32'(m_rcp[j]));
                if (o_done[j] != '0) begin
                    have = (j == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (!have) begin
                        check(j, "done_unexpected", 32'(o_done[j]), 32'd0);
                    end else begin
                        e = (j == 0) ? q0.pop_front() : q1.pop_front();
                        check(j, "sb_done_idx", 32'(o_done[j]), 32'(oh(e.idx)));
                        check(j, "sb_result", 32'(o_result[j]), 32'(e.res));
                        check(j, "sb_sat", 32'(o_sat[j]), 32'(e.sat));
                    end
                end
            end
        end
    end

    // One cycle of requester behaviour; requesters follow the done pulses of instance src.
    task automatic drive_cycle(input int src, input bit rnd);
        @(posedge clk);
        #1;
        if (o_done[src] != '0) ord.push_back(o_done[src]);
        i_flush = rnd && ($urandom_range(0, 49) == 0);
        for (int k = 0; k < NREQ; k++) begin
            if (o_done[src][k]) begin
                if (rnd && $urandom_range(0, 3) == 0) i_data[k*W +: W] = rand_op();
                else i_req[k] = 1'b0;
            end else if (rnd) begin
                if (!i_req[k] && $urandom_range(0, 5) == 0) begin
                    i_req[k] = 1'b1;
                    i_data[k*W +: W] = rand_op();
                end else if (i_req[k] && $urandom_range(0, 19) == 0) begin
                    i_data[k*W +: W] = rand_op();
                end else if (o_gnt[src][k] && $urandom_range(0, 29) == 0) begin
                    i_req[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain();
        i_req   = '0;
        i_flush = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_order(input int j, input string nm, input logic [NREQ-1:0] want[$]);
        check(j, {nm, "_len"}, 32'(ord.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++) begin
            if (i < ord.size()) check(j, nm, 32'(ord[i]), 32'(want[i]));
        end
    endtask

    task automatic check_zero(input string nm);
        for (int j = 0; j < 2; j++) begin
            check(j, {nm, "_gnt"}, 32'(o_gnt[j]), 32'd0);
            check(j, {nm, "_done"}, 32'(o_done[j]), 32'd0);
            check(j, {nm, "_result"}, 32'(o_result[j]), 32'd0);
            check(j, {nm, "_sat"}, 32'(o_sat[j]), 32'd0);
            check(j, {nm, "_busy"}, 32'(o_busy[j]), 32'd0);
            check(j, {nm, "_rcp_in"}, 32'(rcp_in[j]), 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        i_flush = 1'b0;
        i_req   = '0;
        i_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Round-robin from a fresh reset: 0,1,2, then 0,2.
        for (int k = 0; k < NREQ; k++) i_data[k*W +: W] = rand_op();
        ord.delete();
        i_req = 3'b111;
        repeat (14) drive_cycle(0, 1'b0);
        check_order(0, "rr_order_111", '{3'b001, 3'b010, 3'b100});
        ord.delete();
        i_req = 3'b101;
        repeat (10) drive_cycle(0, 1'b0);
        check_order(0, "rr_order_101", '{3'b001, 3'b100});
        drain();

        // Single job, 2.0 -> 0.5.
        i_data[0 +: W] = 24'h002000;
        i_req = 3'b001;
        @(posedge clk); #1;
        check(0, "t1_gnt", 32'(o_gnt[0]), 32'h1);
        @(posedge clk); #1;
        check(0, "t1_early_done", 32'(o_done[0]), 32'h0);
        @(posedge clk); #1;
        check(0, "t1_done", 32'(o_done[0]), 32'h1);
        check(0, "t1_result", 32'(o_result[0]), 32'h000800);
        check(0, "t1_sat", 32'(o_sat[0]), 32'h0);
        check(0, "t1_rcp_in", 32'(rcp_in[0]), 32'h002000);
        drain();

        // Zero operand saturates.
        i_data[W +: W] = '0;
        i_req = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        check(0, "t4_done", 32'(o_done[0]), 32'h2);
        check(0, "t4_sat", 32'(o_sat[0]), 32'h1);
        check(0, "t4_result", 32'(o_result[0]), 32'hFFFFFF);
        drain();

        // Fixed priority: 1 first, then 0 beats 2 once 0 joins mid-job.
        i_req = 3'b110;
        @(posedge clk); #1;
        i_req = 3'b111;
        ord.delete();
        repeat (16) drive_cycle(1, 1'b0);
        check_order(1, "fp_order", '{3'b010, 3'b001, 3'b100});
        drain();

        // Flush one cycle after a grant, held request re-granted afterwards.
        i_data[W +: W] = 24'h004000;
        i_req = 3'b010;
        @(posedge clk); #1;
        i_flush = 1'b1;
        @(posedge clk); #1;
        check(0, "t5_gnt", 32'(o_gnt[0]), 32'h0);
        check(0, "t5_busy", 32'(o_busy[0]), 32'h0);
        check(0, "t5_done", 32'(o_done[0]), 32'h0);
        i_flush = 1'b0;
        @(posedge clk); #1;
        check(0, "t5_regnt", 32'(o_gnt[0]), 32'h2);
        repeat (8) drive_cycle(0, 1'b0);
        drain();

        // Asynchronous reset mid-job, then simultaneous requests 1 and 2.
        i_data[0 +: W] = 24'h003000;
        i_req = 3'b001;
        @(posedge clk); #1;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("t6_arst");
        i_req = 3'b110;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check(0, "t6_gnt", 32'(o_gnt[0]), 32'h2);
        check(1, "t6_gnt", 32'(o_gnt[1]), 32'h2);

        repeat (3000) drive_cycle(0, 1'b1);
        drain();
        check(0, "sb_leftover", 32'(q0.size()), 32'd0);
        check(1, "sb_leftover", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
